// File: rtl/generador_texto.sv
// One-line text banner renderer: font ROM sequencing plus a blanking-committed host char buffer.
// Optional CURSOR_EN adds a blinking inverted cursor on the last written slot.
module generador_texto #(
    parameter int          N_CHARS      = 8,
    parameter int          X0           = 288,
    parameter int          Y0           = 232,
    parameter logic [2:0]  FG_RGB       = 3'b111,
    parameter logic [2:0]  BG_RGB       = 3'b000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pixel_tick,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic                       video_on,
    input  logic                       wr_en,
    input  logic [$clog2(N_CHARS)-1:0] wr_addr,
    input  logic [2:0]                 wr_char,
    output logic                       wr_ready,
    output logic [2:0]                 direccion,
    output logic [3:0]                 rom,
    input  logic [7:0]                 rom_data,
    output logic                       text_on,
    output logic [2:0]                 rgb
);
    localparam int AW = $clog2(N_CHARS);
    localparam logic [9:0] WIN_W = 10'(8 * N_CHARS);

    if (N_CHARS < 2 || N_CHARS > 16 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("generador_texto: bad parameter");
    end

    logic [2:0]    buffer [N_CHARS];
    logic          pend_vld;
    logic [AW-1:0] pend_addr;
    logic [2:0]    pend_char;
    logic          commit;

    logic [9:0]    dx, dy;
    logic [AW-1:0] slot;
    logic          in_win;
    logic [2:0]    bit_sel;
    logic          win0, vid0;
    logic          glyph_bit, pix_on;

    // dx/dy wrap for pixels left of/above the window, so the unsigned compares double as the lower bound
    assign dx     = pixel_x - 10'(X0);
    assign dy     = pixel_y - 10'(Y0);
    assign slot   = dx[AW+2:3];
    assign in_win = video_on && (dx < WIN_W) && (dy < 10'd16);
    assign commit = pend_vld && !video_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_char <= '0;
            wr_ready  <= 1'b1;
            for (int i = 0; i < N_CHARS; i++) buffer[i] <= '0;
        end else if (wr_en && wr_ready) begin
            pend_vld  <= 1'b1;
            pend_addr <= wr_addr;
            pend_char <= wr_char;
            wr_ready  <= 1'b0;
        end else if (commit) begin
            buffer[pend_addr] <= pend_char;
            pend_vld          <= 1'b0;
            wr_ready          <= 1'b1;
        end
    end

    assign glyph_bit = rom_data[3'd7 - bit_sel];

`ifdef CURSOR_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    logic [AW-1:0]   cursor_pos, slot0;
    logic [FC_W-1:0] frame_cnt;
    logic            blink;

    // frame_cnt counts frames entered; blink flips once BLINK_FRAMES have fully elapsed
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_pos <= '0;
            slot0      <= '0;
            frame_cnt  <= '0;
            blink      <= 1'b0;
        end else begin
            if (!(wr_en && wr_ready) && commit) cursor_pos <= pend_addr;
            if (pixel_tick) begin
                slot0 <= slot;
                if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
                    if (frame_cnt == FC_W'(BLINK_FRAMES)) begin
                        frame_cnt <= FC_W'(1);
                        blink     <= ~blink;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign pix_on = win0 && (glyph_bit ^ (blink && slot0 == cursor_pos));
`else
    assign pix_on = win0 && glyph_bit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            direccion <= '0;
            rom       <= '0;
            bit_sel   <= '0;
            win0      <= 1'b0;
            vid0      <= 1'b0;
            text_on   <= 1'b0;
            rgb       <= 3'b000;
        end else if (pixel_tick) begin
            direccion <= buffer[slot];
            rom       <= dy[3:0];
            bit_sel   <= dx[2:0];
            win0      <= in_win;
            vid0      <= video_on;
            text_on   <= pix_on;
            rgb       <= !vid0 ? 3'b000 : !win0 ? 3'b000 : pix_on ? FG_RGB : BG_RGB;
        end
    end
endmodule

// File: tb/tb_generador_texto.sv
// Scoreboard bench for generador_texto: randomized raster/host stimulus vs a pixel-level model.
module tb_generador_texto;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_tick = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic       video_on = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0, wr_char = '0;
    logic       wr_ready;
    logic [2:0] direccion;
    logic [3:0] rom;
    logic [7:0] rom_data;
    logic       text_on;
    logic [2:0] rgb;

    always #5 clk = ~clk;

    generador_texto dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .wr_ready(wr_ready), .direccion(direccion), .rom(rom), .rom_data(rom_data),
        .text_on(text_on), .rgb(rgb)
    );

    logic [7:0] font [8][16];
    assign rom_data = font[direccion][rom];

    typedef struct {
        logic       to;
        logic [2:0] rgb;
        logic [2:0] dir;
        logic [3:0] rom;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // host-visible model: displayed buffer plus one outstanding write
    logic [2:0] mbuf [8];
    bit         pend;
    int         pend_a, pend_c;
    bit         exp_ready;

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t ref_pix(int x, int y, bit vo);
        exp_t e;
        int   dx, dy;
        bit   b;
        dx    = x - 288;
        dy    = y - 232;
        e.dir = mbuf[((x - 288) & 1023) / 8 % 8];
        e.rom = 4'((y - 232) & 15);
        e.to  = 1'b0;
        e.rgb = 3'b000;
        if (vo && dx >= 0 && dx < 64 && dy >= 0 && dy < 16) begin
            b     = font[mbuf[dx / 8]][dy][7 - dx % 8];
            e.to  = b;
            e.rgb = b ? 3'b111 : 3'b000;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mbuf[i] = 3'd0;
        pend      = 1'b0;
        exp_ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic drive(int x, int y, bit vo, bit tk, bit we, int wa, int wc);
        @(negedge clk);
        chk("wr_ready", int'(wr_ready), int'(exp_ready));
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        video_on   = vo;
        pixel_tick = tk;
        wr_en      = we;
        wr_addr    = 3'(wa);
        wr_char    = 3'(wc);
        if (tk) exp_q.push_back(ref_pix(x, y, vo));
        @(posedge clk);
        if (we && exp_ready) begin
            pend = 1'b1; pend_a = wa; pend_c = wc; exp_ready = 1'b0;
        end else if (pend && !vo) begin
            mbuf[pend_a] = 3'(pend_c); pend = 1'b0; exp_ready = 1'b1;
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        reset      = 1'b1;
        pixel_tick = 1'b0;
        wr_en      = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_text_on", int'(text_on), 0);
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_direccion", int'(direccion), 0);
        chk("rst_rom", int'(rom), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        reset = 1'b0;
    endtask

    task automatic host_write(int a, int c, bit vo);
        bit acc;
        for (int i = 0; i < 20; i++) begin
            acc = exp_ready;
            drive(700, 10, vo, 1'b0, 1'b1, a, c);
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL write_timeout: slot %0d never accepted within 20 cycles", a);
    endtask

    // inj: request slot 2 / char 5 mid-line at x=300, then a must-be-ignored request at x=310
    task automatic scan_line(int y, int tick_pct, bit inj);
        bit we;
        int wa, wc;
        for (int x = 0; x < 800; x++) begin
            we = 1'b0; wa = 0; wc = 0;
            if (inj && x == 300) begin we = 1'b1; wa = 2; wc = 5; end
            if (inj && x == 310) begin we = 1'b1; wa = 3; wc = 6; end
            drive(x, y, (x < 640 && y < 480), ($urandom_range(99) < tick_pct), we, wa, wc);
        end
    endtask

    // monitor: after each tick the outputs show the sample taken one tick earlier,
    // while direccion/rom show the sample just taken; between ticks everything holds
    initial begin
        exp_t e, cur;
        logic tk, rs;
        cur.to = 1'b0; cur.rgb = 3'b000; cur.dir = 3'd0; cur.rom = 4'd0;
        forever begin
            @(posedge clk);
            tk = pixel_tick;
            rs = reset;
            #1;
            if (rs) begin
                cur.to = 1'b0; cur.rgb = 3'b000; cur.dir = 3'd0; cur.rom = 4'd0;
            end else begin
                if (tk) begin
                    if (exp_q.size() > 0) begin
                        cur.dir = exp_q[exp_q.size()-1].dir;
                        cur.rom = exp_q[exp_q.size()-1].rom;
                    end
                    while (exp_q.size() >= 2) begin
                        e = exp_q.pop_front();
                        cur.to = e.to;
                        cur.rgb = e.rgb;
                    end
                end
                chk("text_on", int'(text_on), int'(cur.to));
                chk("rgb", int'(rgb), int'(cur.rgb));
                chk("direccion", int'(direccion), int'(cur.dir));
                chk("rom", int'(rom), int'(cur.rom));
            end
        end
    end

    initial begin
        for (int g = 0; g < 8; g++)
            for (int r = 0; r < 16; r++)
                font[g][r] = (g == 0 || g == 7) ? 8'h00 : 8'($urandom);
        font[1][0] = 8'h00; font[1][2] = 8'hFE;
        font[3][2] = 8'h82; font[3][14] = 8'h00;

        model_reset();
        do_reset(3);

        // blank banner after reset
        scan_line(0, 100, 1'b0);
        for (int y = 230; y < 250; y++) scan_line(y, 100, 1'b0);
        scan_line(479, 100, 1'b0);

        // J in slot 0, M in slot 1, written in blanking
        host_write(0, 1, 1'b0);
        drive(700, 10, 1'b0, 1'b0, 1'b0, 0, 0);
        host_write(1, 3, 1'b0);
        drive(700, 10, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int y = 232; y < 248; y++) scan_line(y, 100, 1'b0);

        // mid-line write held off until blanking; second request ignored
        scan_line(234, 100, 1'b1);
        scan_line(235, 100, 1'b0);

        // outputs hold while pixel_tick is low
        drive(289, 234, 1'b1, 1'b1, 1'b0, 0, 0);
        drive(297, 234, 1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++)
            drive(288 + $urandom_range(63), 232 + $urandom_range(15), 1'b1, 1'b0, 1'b0, 0, 0);
        drive(300, 236, 1'b1, 1'b1, 1'b0, 0, 0);

        // randomized raster/host mix
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(1) != 0) ? 270 + $urandom_range(100) : $urandom_range(799),
                  225 + $urandom_range(30), ($urandom_range(3) != 0), ($urandom_range(99) < 70),
                  ($urandom_range(4) == 0), $urandom_range(7), $urandom_range(7));

        // reset mid-frame with a write still pending
        host_write(4, 2, 1'b1);
        drive(290, 234, 1'b1, 1'b1, 1'b0, 0, 0);
        do_reset(1);
        for (int y = 232; y < 236; y++) scan_line(y, 80, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
